// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall vector, flush pulse, load-use detection,
// multi-cycle divide sequencing and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned STALL_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_reg1_read_i,
    input  logic [4:0]         id_reg1_addr_i,
    input  logic               id_reg2_read_i,
    input  logic [4:0]         id_reg2_addr_i,
    input  logic               ex_is_load_i,
    input  logic               ex_wreg_i,
    input  logic [4:0]         ex_waddr_i,
    input  logic               ex_div_start_i,
    input  logic               flush_req_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               div_busy_o,
    output logic               div_done_o,
    output logic [31:0]        stall_cycles_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DIV   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [7:0]         DIV_LOAD  = 8'(DIV_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_DIV = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_LU  = STALL_W'(6'b000111);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [7:0]         div_cnt;
    logic [7:0]         div_cnt_nxt;
    logic               lu;
    logic [STALL_W-1:0] stall;
    logic               busy;
    logic               done;

    assign lu = ex_is_load_i && ex_wreg_i && (ex_waddr_i != 5'd0) &&
                ((id_reg1_read_i && (id_reg1_addr_i == ex_waddr_i)) ||
                 (id_reg2_read_i && (id_reg2_addr_i == ex_waddr_i)));

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        stall       = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_RUN: begin
                if (flush_req_i) begin
                    state_nxt = ST_FLUSH;
                end else if (ex_div_start_i) begin
                    stall       = STALL_DIV;
                    div_cnt_nxt = DIV_LOAD;
                    state_nxt   = ST_DIV;
                end else if (lu) begin
                    stall = STALL_LU;
                end
            end
            ST_DIV: begin
                busy = 1'b1;
                if (flush_req_i) begin
                    div_cnt_nxt = '0;
                    state_nxt   = ST_FLUSH;
                end else if (div_cnt <= 8'd1) begin
                    done        = 1'b1;
                    div_cnt_nxt = '0;
                    state_nxt   = ST_RUN;
                end else begin
                    stall       = STALL_DIV;
                    div_cnt_nxt = div_cnt - 8'd1;
                end
            end
            ST_FLUSH: begin
                state_nxt = flush_req_i ? ST_FLUSH : ST_RUN;
            end
            default: begin
                state_nxt   = ST_RUN;
                div_cnt_nxt = '0;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held.
    assign stall_o    = rst ? '0 : stall;
    assign div_busy_o = rst ? 1'b0 : busy;
    assign div_done_o = rst ? 1'b0 : done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            div_cnt        <= '0;
            flush_o        <= 1'b0;
            stall_cycles_o <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            flush_o <= (state_nxt == ST_FLUSH);
            if ((stall != '0) && (stall_cycles_o != '1)) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven hazard vectors plus
// hand-written divide, flush and reset sequences, checked through a scoreboard.
module tb_pipe_ctrl;

    localparam int unsigned DC = 32;

    logic        clk;
    logic        rst;
    logic        id_reg1_read_i;
    logic [4:0]  id_reg1_addr_i;
    logic        id_reg2_read_i;
    logic [4:0]  id_reg2_addr_i;
    logic        ex_is_load_i;
    logic        ex_wreg_i;
    logic [4:0]  ex_waddr_i;
    logic        ex_div_start_i;
    logic        flush_req_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        div_busy_o;
    logic        div_done_o;
    logic [31:0] stall_cycles_o;

    pipe_ctrl #(.DIV_CYCLES(DC), .STALL_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .ex_is_load_i   (ex_is_load_i),
        .ex_wreg_i      (ex_wreg_i),
        .ex_waddr_i     (ex_waddr_i),
        .ex_div_start_i (ex_div_start_i),
        .flush_req_i    (flush_req_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .div_busy_o     (div_busy_o),
        .div_done_o     (div_done_o),
        .stall_cycles_o (stall_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] stall;
        logic       busy;
        logic       done;
        logic       flush;
        string      tag;
    } exp_t;

    typedef struct {
        logic       r1;
        logic [4:0] a1;
        logic       r2;
        logic [4:0] a2;
        logic       load;
        logic       wreg;
        logic [4:0] waddr;
        logic [5:0] exp_stall;
    } vec_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        id_reg1_read_i = 0; id_reg1_addr_i = 0;
        id_reg2_read_i = 0; id_reg2_addr_i = 0;
        ex_is_load_i = 0; ex_wreg_i = 0; ex_waddr_i = 0;
        ex_div_start_i = 0; flush_req_i = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_is_load_i = 1; ex_wreg_i = 1; ex_waddr_i = r;
        id_reg1_read_i = 1; id_reg1_addr_i = r;
    endtask

    // Push the expectation for this cycle, then compare at mid-cycle and advance.
    task automatic cyc(input logic [5:0] s, input logic b, input logic d,
                       input logic f, input string tag);
        exp_t e;
        exp_t got;
        e.stall = s; e.busy = b; e.done = d; e.flush = f; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        check({got.tag, ".stall"}, 32'(stall_o), 32'(got.stall));
        check({got.tag, ".busy"},  32'(div_busy_o), 32'(got.busy));
        check({got.tag, ".done"},  32'(div_done_o), 32'(got.done));
        check({got.tag, ".flush"}, 32'(flush_o), 32'(got.flush));
        check({got.tag, ".cnt"},   stall_cycles_o, exp_cnt);
        if (rst) exp_cnt = 0;
        else if (got.stall != 0 && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        cyc(6'b0, 0, 0, 0, "reset");
        rst = 0;
    endtask

    task automatic full_divide(input string tag);
        ex_div_start_i = 1;
        cyc(6'b001111, 0, 0, 0, {tag, ".start"});
        // Start held and a hazard present: both must be ignored while busy.
        set_lu(5'd9);
        for (int i = 1; i <= int'(DC) - 2; i++) cyc(6'b001111, 1, 0, 0, {tag, ".busy"});
        clear_inputs();
        cyc(6'b0, 1, 1, 0, {tag, ".done"});
        cyc(6'b0, 0, 0, 0, {tag, ".after"});
        check({tag, ".total"}, stall_cycles_o, 32'(DC - 1));
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 1'b1, 5'd5,  6'b000111};
        vecs[1] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  6'b000000};
        vecs[2] = '{1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  6'b000000};
        vecs[3] = '{1'b0, 5'd0,  1'b0, 5'd7,  1'b1, 1'b1, 5'd7,  6'b000000};
        vecs[4] = '{1'b0, 5'd0,  1'b1, 5'd7,  1'b1, 1'b1, 5'd7,  6'b000111};
        vecs[5] = '{1'b1, 5'd5,  1'b1, 5'd6,  1'b0, 1'b1, 5'd5,  6'b000000};
        vecs[6] = '{1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 1'b0, 5'd5,  6'b000000};
        vecs[7] = '{1'b1, 5'd3,  1'b1, 5'd4,  1'b1, 1'b1, 5'd9,  6'b000000};
        vecs[8] = '{1'b1, 5'd31, 1'b1, 5'd2,  1'b1, 1'b1, 5'd31, 6'b000111};
        vecs[9] = '{1'b0, 5'd0,  1'b1, 5'd12, 1'b1, 1'b1, 5'd12, 6'b000111};

        rst = 1;
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Load-use: one bubble then clear, counter reaches 1.
        for (int i = 0; i < 10; i++) begin
            id_reg1_read_i = vecs[i].r1; id_reg1_addr_i = vecs[i].a1;
            id_reg2_read_i = vecs[i].r2; id_reg2_addr_i = vecs[i].a2;
            ex_is_load_i = vecs[i].load; ex_wreg_i = vecs[i].wreg;
            ex_waddr_i = vecs[i].waddr;
            cyc(vecs[i].exp_stall, 0, 0, 0, $sformatf("vec%0d", i));
            if (i == 1) check("lu_single_cnt", stall_cycles_o, 32'd1);
        end
        clear_inputs();

        do_reset();
        full_divide("div");

        // Flush in the middle of a divide.
        do_reset();
        ex_div_start_i = 1;
        cyc(6'b001111, 0, 0, 0, "fdiv.start");
        ex_div_start_i = 0;
        for (int i = 1; i <= 9; i++) cyc(6'b001111, 1, 0, 0, "fdiv.busy");
        flush_req_i = 1;
        cyc(6'b0, 1, 0, 0, "fdiv.abort");
        flush_req_i = 0;
        cyc(6'b0, 0, 0, 1, "fdiv.flush");
        set_lu(5'd4);
        cyc(6'b000111, 0, 0, 0, "fdiv.run");
        clear_inputs();
        cyc(6'b0, 0, 0, 0, "fdiv.idle");

        // Flush, divide start and hazard together: flush wins.
        flush_req_i = 1; ex_div_start_i = 1; set_lu(5'd6);
        cyc(6'b0, 0, 0, 0, "simul.req");
        clear_inputs();
        cyc(6'b0, 0, 0, 1, "simul.flush");
        cyc(6'b0, 0, 0, 0, "simul.nodiv");

        // Back-to-back flush requests hold FLUSH; divide start and hazard ignored there.
        flush_req_i = 1;
        cyc(6'b0, 0, 0, 0, "ff.req1");
        ex_div_start_i = 1; set_lu(5'd8);
        cyc(6'b0, 0, 0, 1, "ff.req2");
        clear_inputs();
        cyc(6'b0, 0, 0, 1, "ff.hold");
        cyc(6'b0, 0, 0, 0, "ff.run");

        // Reset during a divide, then a clean divide.
        ex_div_start_i = 1;
        cyc(6'b001111, 0, 0, 0, "rdiv.start");
        ex_div_start_i = 0;
        for (int i = 1; i <= 4; i++) cyc(6'b001111, 1, 0, 0, "rdiv.busy");
        rst = 1;
        cyc(6'b0, 0, 0, 0, "rdiv.rst");
        rst = 0;
        cyc(6'b0, 0, 0, 0, "rdiv.post");
        check("rdiv.cnt0", stall_cycles_o, 32'd0);
        full_divide("div2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates the per-stage stall vector and the flush pulse consumed by pc, if_id, id_ex, ex_mem and mem_wb.
- Detects load-use hazards on the decode-stage register read ports.
- Sequences multi-cycle divide operations in EX with an internal busy counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DIV_CYCLES, 32, EX cycles a divide occupies, counting from the start cycle to the result-ready cycle; legal range 2..255.
- STALL_W, 6, stall vector width; fixed at 6.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- id_reg1_read_i  in  1  decode read enable, port 1
- id_reg1_addr_i  in  5  decode read address, port 1 (rs)
- id_reg2_read_i  in  1  decode read enable, port 2
- id_reg2_addr_i  in  5  decode read address, port 2 (rt)
- ex_is_load_i  in  1  instruction in EX is a load
- ex_wreg_i  in  1  EX instruction writes a register
- ex_waddr_i  in  5  EX destination register
- ex_div_start_i  in  1  EX holds a divide needing the multi-cycle unit
- flush_req_i  in  1  flush request (branch mispredict/exception)
- stall_o  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
- flush_o  out  1  one-cycle flush pulse to all pipeline registers
- div_busy_o  out  1  divide unit occupied
- div_done_o  out  1  divide result valid this cycle
- stall_cycles_o  out  32  count of cycles with stall_o != 0

Behaviour:
- Reset (rst=1 at clk edge): state=RUN, div_cnt=0, flush_o=0, stall_cycles_o=0.
  - While rst=1, stall_o=0, div_busy_o=0, div_done_o=0.
- States: RUN, DIV_BUSY, FLUSH.
- Load-use hazard (lu) is combinational. It is true when all of the following hold:
  - ex_is_load_i=1 and ex_wreg_i=1;
  - ex_waddr_i != 0;
  - (id_reg1_read_i=1 and id_reg1_addr_i==ex_waddr_i) or (id_reg2_read_i=1 and id_reg2_addr_i==ex_waddr_i).
- Priority each cycle: rst > flush_req_i > DIV_BUSY/div start > lu.
- RUN:
  - If flush_req_i=1: stall_o=0 and next state FLUSH.
  - Else if ex_div_start_i=1: stall_o=6'b001111, div_cnt<=DIV_CYCLES-1, next state DIV_BUSY.
  - Else if lu=1: stall_o=6'b000111 and stay in RUN. This gives a single bubble, because the load leaves EX next cycle.
  - Else stall_o=0.
- DIV_BUSY:
  - div_busy_o=1.
  - div_cnt decrements by 1 each cycle.
  - While div_cnt>1: stall_o=6'b001111.
  - When div_cnt==1: div_done_o=1, stall_o=0, next state RUN. The pipeline advances with the result.
  - Total stalled cycles per divide = DIV_CYCLES-1 (start cycle included); done-cycle latency = DIV_CYCLES-1 cycles after start.
  - ex_div_start_i is ignored while in DIV_BUSY.
  - lu is masked because 001111 supersedes 000111.
  - flush_req_i aborts the divide: div_cnt<=0, div_done_o=0, stall_o=0, next state FLUSH.
- FLUSH:
  - flush_o=1 for exactly this one cycle, registered (one cycle after flush_req_i is sampled).
  - stall_o=0, div_busy_o=0; next state RUN.
  - flush_req_i=1 again in FLUSH: stay in FLUSH (flush_o held high). ex_div_start_i and lu are ignored.
- stall_cycles_o:
  - Increments on every clk edge where stall_o != 0 and rst=0.
  - Saturates at 32'hFFFF_FFFF (no wrap).
- Reset mid-divide: the next edge returns to RUN with no div_done_o pulse.
- Register 0 never causes a hazard.
- Outputs stall_o and div_done_o are combinational from state/inputs. flush_o and the counters are registered.

Test Plan:
- Load-use: EX load with ex_waddr_i=5, ID reads rs=5 -> stall_o=6'b000111 for 1 cycle, then 0; stall_cycles_o=1.
- No false hazard:
  - load with ex_waddr_i=0 and ID rs=0 -> stall_o=0;
  - load with ex_waddr_i=7, id_reg2_addr_i=7, id_reg2_read_i=0 -> stall_o=0.
- Divide with DIV_CYCLES=32: pulse ex_div_start_i at cycle T ->
  - stall_o=001111 for cycles T..T+30;
  - div_done_o=1 and stall_o=0 at T+31;
  - div_busy_o high T+1..T+31;
  - stall_cycles_o=31.
- Flush mid-divide: flush_req_i at T+10 -> stall_o=0 at T+10, flush_o=1 at T+11, no div_done_o, state RUN at T+12.
- Simultaneous flush_req_i, ex_div_start_i and lu in RUN -> stall_o=0, flush_o=1 next cycle, no divide started.
- Synchronous rst asserted during DIV_BUSY -> next cycle all outputs 0, stall_cycles_o=0; a subsequent divide behaves as in the divide scenario above.
